// File: rtl/cdf_lane_loader.sv
// cdf_lane_loader
//   Captures wide scratchpad read data and presents it to the divider lanes
//   as one batch. A one-entry skid buffer absorbs a single extra read while
//   the divider is stalled. Batches accepted by the divider are counted, and
//   a frame ends after NUM_BATCHES of them.
//
//   Handshake: a batch is offered while cdf_valid is high, and it is held
//   unchanged until a cycle in which div_ready is also high (xfer). There is
//   no back-pressure towards the scratchpad. A read that finds both the output
//   register and the skid buffer occupied is dropped, and this sets the
//   sticky overflow flag.
//
// Ports
//   clk                 in   clock; all state changes on the rising edge
//   reset               in   asynchronous active-high reset
//   enable              in   allows capture of new read data
//   sc_mem_rd_data_rdy  in   one-cycle strobe: sc_mem_rd_data is valid
//   sc_mem_rd_data      in   NUM_PORTS*MEM_W; port p at [p*MEM_W +: MEM_W]
//   div_ready           in   divider lanes accept the presented batch
//   ovf_clr             in   synchronous clear of overflow
//   cdfval_todiv        out  LANES*DATA_W; lane k at [k*DATA_W +: DATA_W]
//   cdf_valid           out  cdfval_todiv holds a batch not yet accepted
//   overflow            out  sticky: read data was dropped
//   batch_cnt           out  number of batches accepted in the current frame
//   done                out  one-cycle pulse when the frame completes
//   state_dbg           out  FSM state (0 = IDLE, 1 = HOLD)
//
// MEM_W must be a multiple of DATA_W. The lane bus and the read bus have the
// same width, so lane k is exactly bits [k*DATA_W +: DATA_W] of the read data.

module cdf_lane_loader #(
  parameter int DATA_W      = 32,
  parameter int MEM_W       = 128,
  parameter int NUM_PORTS   = 2,
  parameter int NUM_BATCHES = 32,
  localparam int LANES      = NUM_PORTS * MEM_W / DATA_W,
  localparam int BUS_W      = LANES * DATA_W,
  localparam int CNT_W      = $clog2(NUM_BATCHES + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       sc_mem_rd_data_rdy,
  input  logic [NUM_PORTS*MEM_W-1:0] sc_mem_rd_data,
  input  logic                       div_ready,
  input  logic                       ovf_clr,
  output logic [BUS_W-1:0]           cdfval_todiv,
  output logic                       cdf_valid,
  output logic                       overflow,
  output logic [CNT_W-1:0]           batch_cnt,
  output logic                       done,
  output logic                       state_dbg
);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BATCHES - 1);

  state_e           state_q;
  logic [BUS_W-1:0] out_q;
  logic [BUS_W-1:0] buf_q;
  logic             buf_full_q;
  logic             ovf_q;
  logic [CNT_W-1:0] cnt_q;
  logic             done_q;

  logic             cap;
  logic             xfer;
  logic             ovf_set;

  assign cap  = enable && sc_mem_rd_data_rdy;
  assign xfer = (state_q == HOLD) && div_ready;
  // A drop happens only when nothing leaves this cycle and both slots are full.
  assign ovf_set = (state_q == HOLD) && !xfer && cap && buf_full_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      out_q      <= '0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      ovf_q      <= 1'b0;
      cnt_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;

      // A set wins over a clear in the same cycle.
      if (ovf_set) begin
        ovf_q <= 1'b1;
      end else if (ovf_clr) begin
        ovf_q <= 1'b0;
      end

      if (xfer) begin
        if (cnt_q == LAST_CNT) begin
          cnt_q  <= '0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end

      case (state_q)
        IDLE: begin
          if (cap) begin
            out_q   <= sc_mem_rd_data;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (xfer) begin
            if (buf_full_q) begin
              // The buffered batch moves up. A new read refills the buffer.
              out_q <= buf_q;
              if (cap) begin
                buf_q <= sc_mem_rd_data;
              end else begin
                buf_full_q <= 1'b0;
              end
            end else if (cap) begin
              out_q <= sc_mem_rd_data;
            end else begin
              state_q <= IDLE;
            end
          end else if (cap && !buf_full_q) begin
            buf_q      <= sc_mem_rd_data;
            buf_full_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cdfval_todiv = out_q;
  assign cdf_valid    = (state_q == HOLD);
  assign overflow     = ovf_q;
  assign batch_cnt    = cnt_q;
  assign done         = done_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_cdf_lane_loader.sv
// Bench for cdf_lane_loader. It uses the default build (8 lanes of 32 bits)
// and also a narrow build (1 port, 16-bit lanes). The reference model treats
// the loader as a two-entry FIFO of batches:
//   - The head of the FIFO is the presented batch.
//   - Each cycle, the head leaves if div_ready is high.
//   - A capture is then pushed if fewer than two entries remain.
//   - Otherwise the capture is dropped and overflow is set.
// Inputs change 1 time unit after the rising edge, and outputs are checked there.

module tb_cdf_lane_loader;

  localparam int NB = 32;

  logic         clk;
  logic         reset;
  logic         enable;
  logic         rdy;
  logic [255:0] rd_data;
  logic         div_ready;
  logic         ovf_clr;
  logic [255:0] cdfval_todiv;
  logic         cdf_valid;
  logic         overflow;
  logic [5:0]   batch_cnt;
  logic         done;
  logic         state_dbg;

  logic [127:0] rd_data16;
  logic [127:0] cdfval16;
  logic         valid16;
  logic         ovf16;
  logic [5:0]   cnt16;
  logic         done16;
  logic         state16;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [255:0] exp_q[$];
  int           m_cnt;
  logic         m_done;
  logic         m_ovf;

  cdf_lane_loader dut (
    .clk(clk), .reset(reset), .enable(enable), .sc_mem_rd_data_rdy(rdy),
    .sc_mem_rd_data(rd_data), .div_ready(div_ready), .ovf_clr(ovf_clr),
    .cdfval_todiv(cdfval_todiv), .cdf_valid(cdf_valid), .overflow(overflow),
    .batch_cnt(batch_cnt), .done(done), .state_dbg(state_dbg)
  );

  cdf_lane_loader #(.DATA_W(16), .MEM_W(128), .NUM_PORTS(1)) dut16 (
    .clk(clk), .reset(reset), .enable(enable), .sc_mem_rd_data_rdy(rdy),
    .sc_mem_rd_data(rd_data16), .div_ready(div_ready), .ovf_clr(ovf_clr),
    .cdfval_todiv(cdfval16), .cdf_valid(valid16), .overflow(ovf16),
    .batch_cnt(cnt16), .done(done16), .state_dbg(state16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [255:0] rand_bus();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom();
    return v;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_cnt  = 0;
    m_done = 1'b0;
    m_ovf  = 1'b0;
  endtask

  task automatic reset_dut();
    reset = 1'b1; enable = 1'b0; rdy = 1'b0; div_ready = 1'b0; ovf_clr = 1'b0;
    rd_data = '0; rd_data16 = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    model_clear();
  endtask

  // driver: advance one clock and update the model with the inputs sampled at that edge
  task automatic step();
    logic cap;
    logic x;
    logic set;
    cap = enable && rdy;
    x   = (exp_q.size() > 0) && div_ready;
    set = 1'b0;
    @(posedge clk);
    m_done = 1'b0;
    if (x) begin
      void'(exp_q.pop_front());
      m_cnt++;
      if (m_cnt == NB) begin
        m_cnt  = 0;
        m_done = 1'b1;
      end
    end
    if (cap) begin
      if (exp_q.size() < 2) exp_q.push_back(rd_data);
      else set = 1'b1;
    end
    if (set) m_ovf = 1'b1;
    else if (ovf_clr) m_ovf = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b0; rdy = 1'b0; div_ready = 1'b0; ovf_clr = 1'b0;
    rd_data = '0; rd_data16 = '0;
    #3;
    checks++;
    if ({cdf_valid, overflow, batch_cnt, done, state_dbg} !== 10'd0 || cdfval_todiv !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got valid=%b ovf=%b cnt=%0d done=%b st=%b data=%h, want all zero",
               cdf_valid, overflow, batch_cnt, done, state_dbg, cdfval_todiv);
    end
    reset_dut();
  endtask

  task automatic test_basic();
    logic [31:0] want [4];
    reset_dut();
    want[0] = 32'd1; want[1] = 32'd2; want[2] = 32'd3; want[3] = 32'd4;
    rd_data = rand_bus();
    rd_data[127:0] = 128'h0000000400000003_0000000200000001;
    enable = 1'b1; rdy = 1'b1; div_ready = 1'b1;
    step();
    rdy = 1'b0;
    checks++;
    if (cdf_valid !== 1'b1) begin
      errors++; $display("FAIL basic_valid: got %b want 1", cdf_valid);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (cdfval_todiv[k*32 +: 32] !== want[k]) begin
        errors++; $display("FAIL basic_lane%0d: got %h want %h", k, cdfval_todiv[k*32 +: 32], want[k]);
      end
    end
    checks++;
    if (cdfval_todiv[255:128] !== rd_data[255:128]) begin
      errors++; $display("FAIL basic_port1: got %h want %h", cdfval_todiv[255:128], rd_data[255:128]);
    end
    step();
    checks++;
    if (cdf_valid !== 1'b0 || batch_cnt !== 6'd1) begin
      errors++; $display("FAIL basic_after: got valid=%b cnt=%0d want valid=0 cnt=1", cdf_valid, batch_cnt);
    end
  endtask

  task automatic test_overflow();
    logic [255:0] a, b, c;
    reset_dut();
    a = rand_bus(); b = rand_bus(); c = rand_bus();
    enable = 1'b1; div_ready = 1'b0; rdy = 1'b1;
    rd_data = a; step();
    rd_data = b; step();
    rd_data = c; step();
    rdy = 1'b0;
    checks++;
    if (cdf_valid !== 1'b1 || cdfval_todiv !== a || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_hold: got valid=%b ovf=%b data=%h want valid=1 ovf=1 data=%h",
                         cdf_valid, overflow, cdfval_todiv, a);
    end
    div_ready = 1'b1;
    step();
    checks++;
    if (cdf_valid !== 1'b1 || cdfval_todiv !== b) begin
      errors++; $display("FAIL ovf_second: got valid=%b data=%h want valid=1 data=%h", cdf_valid, cdfval_todiv, b);
    end
    step();
    checks++;
    if (cdf_valid !== 1'b0 || batch_cnt !== 6'd2 || overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_drain: got valid=%b cnt=%0d ovf=%b want 0/2/1", cdf_valid, batch_cnt, overflow);
    end
  endtask

  task automatic test_ovf_clr();
    // Fill both slots, then drop a read in the same cycle as a clear. The set must win.
    enable = 1'b1; div_ready = 1'b0; rdy = 1'b1; ovf_clr = 1'b0;
    rd_data = rand_bus(); step();
    rd_data = rand_bus(); step();
    ovf_clr = 1'b1;
    rd_data = rand_bus(); step();
    rdy = 1'b0;
    checks++;
    if (overflow !== 1'b1) begin
      errors++; $display("FAIL ovf_set_beats_clr: got %b want 1", overflow);
    end
    step();
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b want 0", overflow);
    end
    div_ready = 1'b1;
    step(); step();
    checks++;
    if (cdf_valid !== m_done || cdf_valid !== 1'b0) begin
      errors++; $display("FAIL ovf_clr_drain: got valid=%b want 0", cdf_valid);
    end
  endtask

  task automatic test_back_to_back();
    int done_seen;
    reset_dut();
    done_seen = 0;
    enable = 1'b1; div_ready = 1'b1;
    for (int i = 0; i < NB + 3; i++) begin
      rdy = (i < NB);
      rd_data = rand_bus();
      step();
      if (done === 1'b1) done_seen++;
      checks++;
      if (cdf_valid !== (exp_q.size() > 0) || batch_cnt !== m_cnt[5:0] || done !== m_done) begin
        errors++; $display("FAIL b2b_cycle%0d: got valid=%b cnt=%0d done=%b want %b/%0d/%b",
                           i, cdf_valid, batch_cnt, done, exp_q.size() > 0, m_cnt, m_done);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (cdfval_todiv !== exp_q[0]) begin
          errors++; $display("FAIL b2b_data%0d: got %h want %h", i, cdfval_todiv, exp_q[0]);
        end
      end
    end
    checks++;
    if (done_seen != 1 || batch_cnt !== 6'd0) begin
      errors++; $display("FAIL b2b_frame: got done_pulses=%0d cnt=%0d want 1/0", done_seen, batch_cnt);
    end
  endtask

  task automatic test_enable_low();
    logic [5:0]   cnt_before;
    logic [255:0] d, e;
    cnt_before = batch_cnt;
    enable = 1'b0; rdy = 1'b1; div_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_data = rand_bus();
      step();
      checks++;
      if (cdf_valid !== 1'b0 || batch_cnt !== cnt_before) begin
        errors++; $display("FAIL enable_low%0d: got valid=%b cnt=%0d want 0/%0d", i, cdf_valid, batch_cnt, cnt_before);
      end
    end
    // Dropping enable while data is held must not lose it.
    d = rand_bus(); e = rand_bus();
    enable = 1'b1; div_ready = 1'b0;
    rd_data = d; step();
    rd_data = e; step();
    enable = 1'b0; div_ready = 1'b1;
    rd_data = rand_bus();
    step();
    checks++;
    if (cdf_valid !== 1'b1 || cdfval_todiv !== e) begin
      errors++; $display("FAIL enable_drain: got valid=%b data=%h want 1 %h", cdf_valid, cdfval_todiv, e);
    end
    step();
    checks++;
    if (cdf_valid !== 1'b0 || batch_cnt !== m_cnt[5:0]) begin
      errors++; $display("FAIL enable_drain_end: got valid=%b cnt=%0d want 0/%0d", cdf_valid, batch_cnt, m_cnt);
    end
  endtask

  task automatic test_reset_mid();
    reset_dut();
    enable = 1'b1; div_ready = 1'b1; rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd_data = rand_bus(); step();
    end
    rdy = 1'b0; step();
    div_ready = 1'b0; rdy = 1'b1;
    rd_data = rand_bus(); step();
    rd_data = rand_bus(); step();
    rdy = 1'b0;
    checks++;
    if (batch_cnt !== 6'd5 || state_dbg !== 1'b1 || exp_q.size() != 2) begin
      errors++; $display("FAIL mid_setup: got cnt=%0d st=%b want 5/1", batch_cnt, state_dbg);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({cdf_valid, overflow, batch_cnt, done, state_dbg} !== 10'd0 || cdfval_todiv !== '0) begin
      errors++; $display("FAIL mid_reset_async: got valid=%b cnt=%0d st=%b data=%h want zeros",
                         cdf_valid, batch_cnt, state_dbg, cdfval_todiv);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || cdf_valid !== 1'b0) begin
      errors++; $display("FAIL mid_reset_done: got done=%b valid=%b want 0/0", done, cdf_valid);
    end
    reset = 1'b0;
    model_clear();
    // After reset, the first batch accepted is counted from zero again.
    enable = 1'b1; rdy = 1'b1; div_ready = 1'b1; rd_data = rand_bus();
    step(); rdy = 1'b0; step();
    checks++;
    if (batch_cnt !== 6'd1) begin
      errors++; $display("FAIL mid_new_frame: got cnt=%0d want 1", batch_cnt);
    end
  endtask

  task automatic test_narrow();
    reset_dut();
    for (int i = 0; i < 4; i++) rd_data16[i*32 +: 32] = $urandom();
    enable = 1'b1; rdy = 1'b1; div_ready = 1'b0;
    step();
    rdy = 1'b0;
    checks++;
    if (valid16 !== 1'b1 || cdfval16[127:112] !== rd_data16[127:112] || cdfval16[15:0] !== rd_data16[15:0]) begin
      errors++; $display("FAIL narrow_lanes: got valid=%b lane7=%h lane0=%h want 1 %h %h",
                         valid16, cdfval16[127:112], cdfval16[15:0], rd_data16[127:112], rd_data16[15:0]);
    end
    div_ready = 1'b1; step(); step();
  endtask

  task automatic test_random();
    reset_dut();
    for (int i = 0; i < 400; i++) begin
      enable    = ($urandom_range(0, 3) != 0);
      rdy       = $urandom_range(0, 1);
      div_ready = $urandom_range(0, 1);
      ovf_clr   = ($urandom_range(0, 7) == 0);
      rd_data   = rand_bus();
      step();
      checks++;
      if (cdf_valid !== (exp_q.size() > 0) || state_dbg !== (exp_q.size() > 0) || overflow !== m_ovf ||
          batch_cnt !== m_cnt[5:0] || done !== m_done) begin
        errors++; $display("FAIL rand_ctrl%0d: got v=%b st=%b o=%b c=%0d d=%b want v=%b o=%b c=%0d d=%b",
                           i, cdf_valid, state_dbg, overflow, batch_cnt, done,
                           exp_q.size() > 0, m_ovf, m_cnt, m_done);
      end
      if (exp_q.size() > 0) begin
        checks++;
        if (cdfval_todiv !== exp_q[0]) begin
          errors++; $display("FAIL rand_data%0d: got %h want %h", i, cdfval_todiv, exp_q[0]);
        end
      end
    end
    ovf_clr = 1'b0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_basic();
    test_overflow();
    test_ovf_clr();
    test_back_to_back();
    test_enable_low();
    test_reset_mid();
    test_narrow();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
